// File: rtl/ones_pattern_pkg.sv
// ones_pattern_pkg: shared state type and mask/popcount helpers for fixed-weight word generation
package ones_pattern_pkg;
  localparam int MAXW = 16;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic [MAXW-1:0] low_mask(input int k);
    logic [MAXW:0] m;
    m = ((MAXW+1)'(1) << k) - (MAXW+1)'(1);
    return m[MAXW-1:0];
  endfunction
  function automatic logic [MAXW-1:0] top_mask(input int k, input int w);
    return low_mask(k) << (w - k);
  endfunction
  function automatic int popcount(input logic [MAXW-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < MAXW; i++) n += int'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/ones_pattern_gen_tz_count.sv
// tz_count: combinational trailing-zero counter (i_x in, o_tz out; all-zero input gives WIDTH)
module tz_count #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [KW-1:0]    o_tz
);
  always_comb begin
    o_tz = KW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) if (i_x[i]) o_tz = KW'(i);
  end
endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: streams every WIDTH-bit word with exactly k_in ones, ascending, over valid/ready
// Ports: clk/rst_n clock and async active-low reset; start/k_in request; busy status;
// pattern_out/pattern_idx/valid/last/ready output stream; err pulse on k_in > WIDTH.
module ones_pattern_gen
  import ones_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    k_in,
  output logic             busy,
  output logic [WIDTH-1:0] pattern_out,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic [WIDTH-1:0] pattern_idx,
  output logic             err
);
  state_t           r_state, w_state_nxt;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_pat, r_idx;
  logic             r_err;
  logic [KW-1:0]    w_tz;
  logic [WIDTH:0]   w_x, w_c, w_r;
  logic [WIDTH-1:0] w_nxt, w_low, w_top;
  logic             w_bad, w_accept, w_adv;
  tz_count #(.WIDTH(WIDTH), .KW(KW)) u_tz (.i_x(r_pat), .o_tz(w_tz));
  assign w_bad    = k_in > KW'(WIDTH);
  assign w_accept = r_state == IDLE && start && !w_bad;
  assign w_adv    = valid && ready && !last;
  // Gosper step: lowest set bit ripples up, displaced ones refill from bit 0
  assign w_x   = {1'b0, r_pat};
  assign w_c   = w_x & (-w_x);
  assign w_r   = w_x + w_c;
  assign w_nxt = WIDTH'(w_r | (((w_r ^ w_x) >> 2) >> w_tz));
  assign w_low = WIDTH'(low_mask(int'(k_in)));
  assign w_top = WIDTH'(top_mask(int'(r_k), WIDTH));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && w_accept) w_state_nxt = EMIT;
    if (r_state == EMIT && valid && ready && last) w_state_nxt = IDLE;
  end
  always_comb begin
    busy        = r_state == EMIT;
    valid       = r_state == EMIT;
    last        = valid && r_pat == w_top;
    pattern_out = r_pat;
    pattern_idx = r_idx;
    err         = r_err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_k   <= '0;
      r_pat <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= r_state == IDLE && start && w_bad;
      if (w_accept) begin
        r_k   <= k_in;
        r_pat <= w_low;
        r_idx <= '0;
      end else if (w_adv) begin
        r_pat <= w_nxt;
        r_idx <= r_idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed scoreboard bench for ones_pattern_gen (WIDTH=8)
module tb_ones_pattern_gen;
  import ones_pattern_pkg::*;
  logic       clk = 0, rst_n = 0, start = 0, ready = 0;
  logic [3:0] k_in = '0;
  logic       busy, valid, last, err;
  logic [7:0] pattern_out, pattern_idx;
  logic [7:0] q[$];
  int total = 0, bad = 0, cur_k = 0;
  ones_pattern_gen #(.WIDTH(8), .KW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_in(k_in), .busy(busy),
    .pattern_out(pattern_out), .valid(valid), .ready(ready), .last(last),
    .pattern_idx(pattern_idx), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_expected(input int k);
    cur_k = k;
    q.delete();
    for (int v = 0; v < 256; v++) if ($countones(8'(v)) == k) q.push_back(8'(v));
  endtask
  task automatic kick(input int k);
    push_expected(k);
    start = 1;
    k_in  = 4'(k);
    @(negedge clk);
    start = 0;
    chk("valid_lat", valid, 1);
    chk("busy_on", busy, 1);
  endtask
  task automatic run_seq(input bit rnd, input int max_beats, input int exp_beats);
    int beats = 0, cyc = 0;
    bit stall = 0;
    logic [7:0] prev_pat = '0, prev_idx = '0, prev_hs = '0, e;
    while (q.size() > 0 && beats < max_beats && cyc < 4000) begin
      if (stall) begin
        chk("stable_pat", pattern_out, prev_pat);
        chk("stable_idx", pattern_idx, prev_idx);
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && ready) begin
        e = q.pop_front();
        chk("pattern", pattern_out, e);
        chk("idx", pattern_idx, beats);
        chk("last", last, q.size() == 0);
        chk("popcount", popcount(16'(pattern_out)), cur_k);
        if (beats > 0) chk("ascending", pattern_out > prev_hs, 1);
        prev_hs = pattern_out;
        beats++;
      end
      stall    = valid && !ready;
      prev_pat = pattern_out;
      prev_idx = pattern_idx;
      @(negedge clk);
      cyc++;
    end
    chk("beats", beats, exp_beats);
    ready = 0;
  endtask
  initial begin
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", last, 0);
    chk("rst_err", err, 0);
    chk("rst_pat", pattern_out, 0);
    chk("rst_idx", pattern_idx, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    kick(2);
    chk("first_k2", pattern_out, 8'h03);
    run_seq(0, 1000, 28);
    chk("busy_off_k2", busy, 0);
    chk("valid_off_k2", valid, 0);
    chk("hold_pat_k2", pattern_out, 8'hC0);
    kick(0);
    run_seq(0, 1000, 1);
    chk("busy_off_k0", busy, 0);
    push_expected(8);
    start = 1;
    k_in  = 4'd8;
    @(negedge clk);
    ready = 1;
    k_in  = 4'd9;
    chk("k8_pat", pattern_out, 8'hFF);
    chk("k8_last", last, 1);
    chk("k8_idx", pattern_idx, 0);
    @(negedge clk);
    start = 0;
    ready = 0;
    chk("k8_done_valid", valid, 0);
    chk("k8_done_busy", busy, 0);
    chk("busy_start_no_err", err, 0);
    @(negedge clk);
    chk("busy_start_ignored", valid, 0);
    chk("k8_hold", pattern_out, 8'hFF);
    start = 1;
    k_in  = 4'd9;
    @(negedge clk);
    start = 0;
    chk("err_pulse", err, 1);
    chk("err_valid", valid, 0);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("err_stay_idle", valid, 0);
    kick(4);
    run_seq(1, 1000, 70);
    chk("busy_off_k4", busy, 0);
    kick(3);
    run_seq(0, 10, 10);
    chk("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", last, 0);
    chk("arst_pat", pattern_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    kick(1);
    run_seq(0, 1000, 8);
    chk("hold_pat_k1", pattern_out, 8'h80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Inverse of the ones-count block: given a requested ones count K, emits every WIDTH-bit word containing exactly K set bits.
- Words come out one per accepted beat, in ascending numeric order, over a valid/ready stream with a last marker.
- Used to drive exhaustive stimulus into popcount/parity logic and to produce fixed-weight codewords for the lab datapath.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..16.
- KW, $clog2(WIDTH+1), width of the requested-count input (4 for WIDTH=8).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new sequence; sampled only when busy=0.
- k_in  input  KW  requested number of ones; sampled with start.
- busy  output  1  high from the cycle after an accepted start until the cycle after the last handshake.
- pattern_out  output  WIDTH  current word, registered.
- valid  output  1  pattern_out holds a valid word.
- ready  input  1  consumer accepts the word; a beat transfers when valid && ready.
- last  output  1  qualifies pattern_out as the final word of the sequence.
- pattern_idx  output  WIDTH  zero-based index of the current word within the sequence.
- err  output  1  one-cycle pulse when start is seen with k_in > WIDTH.

Behaviour:
- Reset (async assert, synchronous deassert handled by flops): state=IDLE; busy, valid, last and err are 0; pattern_out and pattern_idx are 0.
- FSM has two states, IDLE and EMIT.
- IDLE, start=1, k_in<=WIDTH:
  - Next cycle: state=EMIT, busy=1, valid=1, pattern_out=(1<<k_in)-1, pattern_idx=0.
  - Latency from start to first valid is 1 cycle.
- IDLE, start=1, k_in>WIDTH: err=1 for exactly one cycle; stay in IDLE; no beats are emitted.
- EMIT with valid && !ready: pattern_out, pattern_idx and last hold stable. Backpressure may last indefinitely.
- EMIT with valid && ready && !last:
  - Next cycle, pattern_out = next(x), where x is the current word.
  - pattern_idx increments by 1.
  - valid stays 1, so the block sustains 1 word per cycle under ready=1.
- next(x), a Gosper step computed in WIDTH+1 bits:
  - c = x & -x
  - r = x + c
  - tz = trailing-zero count of x
  - next = r | (((r ^ x) >> 2) >> tz)
- last = 1 when pattern_out equals the top-K mask ((1<<K)-1) << (WIDTH-K). K is latched at start.
- K=0: a single beat of 0x00 with last=1, since the mask is 0 and equals the top mask.
- K=WIDTH: a single beat of all ones with last=1.
- EMIT with valid && ready && last: next cycle state=IDLE, valid=0, last=0, busy=0. pattern_out and pattern_idx keep their final values.
- start while busy=1, including the last-handshake cycle, is ignored and does not raise err.
- Total beats for count K equal C(WIDTH,K), e.g. 70 for WIDTH=8, K=4. This count always fits in pattern_idx.
- Reset asserted mid-sequence: immediate return to reset values. The sequence is abandoned with no partial completion.
- k_in changing while busy has no effect, because K was latched at start.

Decomposition:
- Package ones_pattern_pkg holds:
  - the state enum {IDLE, EMIT};
  - a function top_mask(k);
  - a function low_mask(k).
- One natural sub-module: tz_count. It is a combinational trailing-zero counter, WIDTH bits in and $clog2(WIDTH+1) bits out, and it supplies tz for the next(x) step.
- The popcount function is shared with the ones-count block so the bench can self-check every word.

Test Plan:
- k_in=2, start pulse, ready=1:
  - first valid one cycle later with sequence 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11, …;
  - 28 beats total; last=1 only on 0xC0;
  - busy drops the cycle after.
- k_in=0 -> exactly one beat 0x00, last=1, pattern_idx=0.
- k_in=8 -> exactly one beat 0xFF, last=1.
- k_in=9 -> err high for 1 cycle; valid and busy stay 0.
- k_in=4 with ready toggled randomly:
  - 70 beats, all distinct, strictly ascending, each with popcount 4;
  - pattern_out stable while ready=0.
- k_in=3, rst_n pulled low after 10 beats:
  - valid, busy and last are 0 asynchronously;
  - a fresh start with k_in=1 then yields 0x01, 0x02, …, 0x80, 8 beats.
